// File: rtl/output_token_writer_if.sv
// Token-side and output-FIFO-side signals of the output token writer.
// The writer connects through the slave modport; the mux/FIFO side uses master.
interface output_token_writer_if #(
   parameter int word_size = 16
);
   logic                     out_valid;
   logic [2*word_size-1:0]   output_token;
   logic                     out_full;
   logic                     wr_en;
   logic [2*word_size-1:0]   wr_data;

   modport master (
      output out_valid, output_token, out_full,
      input  wr_en, wr_data
   );

   modport slave (
      input  out_valid, output_token, out_full,
      output wr_en, wr_data
   );
endinterface

// File: rtl/output_token_writer.sv
// Buffers output tokens of one firing and drains them into the output FIFO,
// then pulses done once every token has been written or dropped.
module output_token_writer #(
   parameter int word_size    = 16,
   parameter int buffer_depth = 8,
   parameter int cnt_width    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            instr,
   input  logic [cnt_width-1:0]  num_tokens,
   output_token_writer_if.slave  tok,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int tok_w = 2 * word_size;
   localparam int ptr_w = (buffer_depth > 1) ? $clog2(buffer_depth) : 1;
   localparam int occ_w = ptr_w + 1;
   localparam logic [occ_w-1:0] depth_occ = occ_w'(buffer_depth);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [cnt_width-1:0]   rem_in_q, rem_in_d;
   logic [cnt_width-1:0]   rem_out_q, rem_out_d;
   logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
   logic [occ_w-1:0]       count_q, count_d;
   logic                   err_q, err_d;
   logic [tok_w-1:0]       mem_q [buffer_depth];
   logic [tok_w-1:0]       mem_d [buffer_depth];

   logic                   pop_s;
   logic                   push_s;
   logic                   drop_s;
   logic                   capture_s;
   logic                   proto_err_s;
   logic                   unused_instr_s;

   assign unused_instr_s = ^instr[7:2];

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign err         = err_q;
   assign pop_s       = busy & (count_q != {occ_w{1'b0}}) & ~tok.out_full;
   assign tok.wr_en   = pop_s;
   assign tok.wr_data = pop_s ? mem_q[rd_ptr_q] : {tok_w{1'b0}};

   // Next-state computation: capture/drop, drain, counters and FSM transitions.
   always_comb begin
      state_d     = state_q;
      rem_in_d    = rem_in_q;
      rem_out_d   = rem_out_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_d       = mem_q;
      push_s      = 1'b0;
      drop_s      = 1'b0;
      proto_err_s = 1'b0;

      capture_s = (state_q == COLLECT) & tok.out_valid & (rem_in_q != {cnt_width{1'b0}});

      if (capture_s) begin
         if (count_q == depth_occ) begin
            drop_s = 1'b1;
         end else begin
            push_s = 1'b1;
         end
      end else begin
         proto_err_s = tok.out_valid;
      end

      if (start && (state_q != IDLE)) begin
         proto_err_s = 1'b1;
      end else begin
         proto_err_s = proto_err_s;
      end

      err_d = err_q | proto_err_s | drop_s;

      if (push_s) begin
         mem_d[wr_ptr_q] = tok.output_token;
         wr_ptr_d        = wr_ptr_q + ptr_w'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + ptr_w'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      count_d   = count_q + occ_w'(push_s) - occ_w'(pop_s);
      rem_in_d  = rem_in_q - cnt_width'(push_s | drop_s);
      // A dropped token still counts toward the firing so that it terminates.
      rem_out_d = rem_out_q - cnt_width'(pop_s) - cnt_width'(drop_s);

      case (state_q)
         IDLE: begin
            if (start) begin
               if (instr[1:0] == 2'b11) begin
                  state_d = FLUSH;
               end else if (num_tokens == {cnt_width{1'b0}}) begin
                  state_d = DONE;
               end else begin
                  state_d   = COLLECT;
                  rem_in_d  = num_tokens;
                  rem_out_d = num_tokens;
               end
            end else begin
               state_d = IDLE;
            end
         end
         COLLECT: begin
            if (rem_out_d == {cnt_width{1'b0}}) begin
               state_d = DONE;
            end else begin
               state_d = COLLECT;
            end
         end
         FLUSH: begin
            state_d  = DONE;
            wr_ptr_d = {ptr_w{1'b0}};
            rd_ptr_d = {ptr_w{1'b0}};
            count_d  = {occ_w{1'b0}};
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; asynchronous reset discards any buffered tokens.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rem_in_q  <= {cnt_width{1'b0}};
         rem_out_q <= {cnt_width{1'b0}};
         wr_ptr_q  <= {ptr_w{1'b0}};
         rd_ptr_q  <= {ptr_w{1'b0}};
         count_q   <= {occ_w{1'b0}};
         err_q     <= 1'b0;
         mem_q     <= '{default: {tok_w{1'b0}}};
      end else begin
         state_q   <= state_d;
         rem_in_q  <= rem_in_d;
         rem_out_q <= rem_out_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_q     <= err_d;
         mem_q     <= mem_d;
      end
   end
endmodule
